// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : In-system program loader.  Parses framed images arriving on the
//             UART receive byte stream, writes them word-by-word through the
//             SoC debug memory port while holding the CPU in reset, answers
//             each frame with an ACK (0x5A) or NAK (0xEE) byte on the UART
//             transmitter, and releases the CPU after a good frame.
//
//  Frame    : SYNC | ADDR[4] (LE) | N[2] (LE) | N x DATA[4] (LE)
//
//  Ports    : clk          system clock, single domain
//             reset        synchronous active-high reset
//             rx_data/rx_valid   received byte + one-cycle strobe
//             tx_data/tx_valid/tx_ready  response byte handshake
//             dbg_mem_op   one-cycle write strobe per word
//             dbg_wren     byte enables (4'hF with the strobe, else 0)
//             dbg_adr      word write address
//             dbg_do       write data
//             cpu_n_reset  CPU reset, active low
//             busy         high whenever not idle
//             err          sticky NAK flag, cleared by the next ACK
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_boot_loader #(
    parameter int         F_CLK     = 12000000,
    parameter int         TIMEOUT   = F_CLK / 100,
    parameter bit         BOOT_HOLD = 1'b1,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    output logic        cpu_n_reset,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ADDR = 3'd1;
    localparam logic [2:0] c_CNT  = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
    localparam logic [2:0] c_ACK  = 3'd4;
    localparam logic [2:0] c_NAK  = 3'd5;

    localparam logic [7:0] c_ACK_BYTE = 8'h5A;
    localparam logic [7:0] c_NAK_BYTE = 8'hEE;

    // Timer only ever counts up to TIMEOUT-1 before the frame is abandoned.
    localparam int             c_TW       = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TMR_ONE  = c_TW'(1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [15:0]     r_cnt;
    logic [31:0]     r_word;
    logic [c_TW-1:0] r_timer;

    logic            r_dbg_mem_op;
    logic [31:0]     r_dbg_adr;
    logic [31:0]     r_dbg_do;
    logic            r_cpu_n_reset;
    logic            r_err;

    logic            w_hs;
    logic            w_timeout;
    logic            w_word_done;
    logic            w_in_frame;
    logic [15:0]     w_cnt_full;

    // ------------------------------------------------------------------------
    // Outputs derived from state: the response byte is a pure function of the
    // state register, so it cannot change while tx_valid is held.
    // ------------------------------------------------------------------------
    assign tx_valid    = (r_state == c_ACK) || (r_state == c_NAK);
    assign tx_data     = (r_state == c_ACK) ? c_ACK_BYTE :
                         (r_state == c_NAK) ? c_NAK_BYTE : 8'h00;
    assign busy        = (r_state != c_IDLE);
    assign dbg_mem_op  = r_dbg_mem_op;
    assign dbg_wren    = {4{r_dbg_mem_op}};
    assign dbg_adr     = r_dbg_adr;
    assign dbg_do      = r_dbg_do;
    assign cpu_n_reset = r_cpu_n_reset;
    assign err         = r_err;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_hs         = tx_valid && tx_ready;
        w_timeout    = (r_timer == c_TMO_LAST);
        w_in_frame   = (r_state == c_ADDR) || (r_state == c_CNT) || (r_state == c_DATA);
        w_word_done  = (r_state == c_DATA) && rx_valid && (r_byte_cnt == 2'd3);
        // Count is shifted in LSB first, so the first byte sits in [15:8].
        w_cnt_full   = {rx_data, r_cnt[15:8]};

        case (r_state)
            c_IDLE: begin
                if (rx_valid && (rx_data == SYNC)) begin
                    w_next_state = c_ADDR;
                end
            end
            c_ADDR: begin
                if (rx_valid) begin
                    if (r_byte_cnt == 2'd3) begin
                        w_next_state = c_CNT;
                    end
                end else if (w_timeout) begin
                    w_next_state = c_NAK;
                end
            end
            c_CNT: begin
                if (rx_valid) begin
                    if (r_byte_cnt == 2'd1) begin
                        if (r_addr[1:0] != 2'b00) begin
                            w_next_state = c_NAK;
                        end else if (w_cnt_full == 16'd0) begin
                            w_next_state = c_ACK;
                        end else begin
                            w_next_state = c_DATA;
                        end
                    end
                end else if (w_timeout) begin
                    w_next_state = c_NAK;
                end
            end
            c_DATA: begin
                if (rx_valid) begin
                    // Last word: leave as its strobe is being launched.
                    if ((r_byte_cnt == 2'd3) && (r_cnt == 16'd1)) begin
                        w_next_state = c_ACK;
                    end
                end else if (w_timeout) begin
                    w_next_state = c_NAK;
                end
            end
            c_ACK, c_NAK: begin
                if (w_hs) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_byte_cnt    <= 2'd0;
            r_addr        <= 32'd0;
            r_cnt         <= 16'd0;
            r_word        <= 32'd0;
            r_timer       <= '0;
            r_dbg_mem_op  <= 1'b0;
            r_dbg_adr     <= 32'd0;
            r_dbg_do      <= 32'd0;
            r_cpu_n_reset <= ~BOOT_HOLD;
            r_err         <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Strobe lasts exactly the cycle after the fourth byte.
            r_dbg_mem_op <= w_word_done;

            // Inter-byte idle timer, only meaningful inside a frame.
            if (w_in_frame && !rx_valid) begin
                r_timer <= r_timer + c_TMR_ONE;
            end else begin
                r_timer <= '0;
            end

            case (r_state)
                c_IDLE: begin
                    r_byte_cnt <= 2'd0;
                    if (rx_valid && (rx_data == SYNC)) begin
                        r_cpu_n_reset <= 1'b0;
                    end
                end
                c_ADDR: begin
                    if (rx_valid) begin
                        r_addr     <= {rx_data, r_addr[31:8]};
                        // Wraps 3 -> 0, which is the start value for CNT.
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                c_CNT: begin
                    if (rx_valid) begin
                        r_cnt      <= w_cnt_full;
                        r_byte_cnt <= (r_byte_cnt == 2'd1) ? 2'd0 : (r_byte_cnt + 2'd1);
                    end
                end
                c_DATA: begin
                    if (rx_valid) begin
                        r_word     <= {rx_data, r_word[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_dbg_adr <= r_addr;
                            r_dbg_do  <= {rx_data, r_word[31:8]};
                            r_addr    <= r_addr + 32'd4;
                            r_cnt     <= r_cnt - 16'd1;
                        end
                    end
                end
                c_ACK: begin
                    if (w_hs) begin
                        r_cpu_n_reset <= 1'b1;
                        r_err         <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            // Error flag rises on entry to NAK, whatever the cause.
            if ((w_next_state == c_NAK) && (r_state != c_NAK)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Purpose  : Self-checking bench for uart_boot_loader.  A table of frames
//             with hand-computed responses and writes, plus directed
//             sequences for timeout, held-off ACK and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        cpu_n_reset;
    logic        busy;
    logic        err;

    uart_boot_loader #(
        .F_CLK     (12000000),
        .TIMEOUT   (100),
        .BOOT_HOLD (1'b1),
        .SYNC      (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dbg_mem_op  (dbg_mem_op),
        .dbg_wren    (dbg_wren),
        .dbg_adr     (dbg_adr),
        .dbg_do      (dbg_do),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  resp;
        logic        exp_err;
        logic        exp_cpu;
        int          nwr;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [31:0] d1;
    } vec_t;
    vec_t vec[5];

    logic [31:0] wd;
    logic        hold_bad;
    int          cyc;

    // Write-port monitor at the falling edge: logs writes and checks strobe
    // shape and response-byte stability.
    logic       prev_op  = 1'b0;
    logic       prev_txv = 1'b0;
    logic [7:0] prev_txd = 8'h00;
    always @(negedge clk) begin
        if (dbg_mem_op) begin
            wr_q.push_back('{dbg_adr, dbg_do});
            checks++;
            if (prev_op || dbg_wren != 4'hF) begin
                errors++;
                $display("FAIL strobe_shape prev_op=%0b wren=%h required prev_op=0 wren=f",
                         prev_op, dbg_wren);
            end
        end else if (dbg_wren != 4'h0) begin
            checks++;
            errors++;
            $display("FAIL wren_idle actual=%h required=0", dbg_wren);
        end
        if (prev_txv && tx_valid && (tx_data != prev_txd)) begin
            checks++;
            errors++;
            $display("FAIL tx_stable actual=%h required=%h", tx_data, prev_txd);
        end
        prev_op  = dbg_mem_op;
        prev_txv = tx_valid;
        prev_txd = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_hdr(input logic [31:0] addr, input logic [15:0] n);
        send(8'hA5);
        check("sync_cpu_held", {31'd0, cpu_n_reset}, 32'd0);
        check("sync_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send(addr[8*i +: 8]);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic wait_tx(output int c);
        c = 0;
        while (!tx_valid && c < 300) begin
            tick();
            c++;
        end
    endtask

    initial begin
        vec[0] = '{32'h00020000, 16'd2, 32'h000107B7, 32'h06100513, 8'h5A, 1'b0, 1'b1,
                   2, 32'h00020000, 32'h000107B7, 32'h00020004, 32'h06100513};
        vec[1] = '{32'h00020002, 16'd1, 32'h0, 32'h0, 8'hEE, 1'b1, 1'b0,
                   0, 32'h0, 32'h0, 32'h0, 32'h0};
        vec[2] = '{32'h00020000, 16'd0, 32'h0, 32'h0, 8'h5A, 1'b0, 1'b1,
                   0, 32'h0, 32'h0, 32'h0, 32'h0};
        vec[3] = '{32'hFFFFFFFC, 16'd2, 32'hA5A5A5A5, 32'h12345678, 8'h5A, 1'b0, 1'b1,
                   2, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h00000000, 32'h12345678};
        vec[4] = '{32'h00001003, 16'd0, 32'h0, 32'h0, 8'hEE, 1'b1, 1'b0,
                   0, 32'h0, 32'h0, 32'h0, 32'h0};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_op", {31'd0, dbg_mem_op}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_adr", dbg_adr, 32'd0);

        // A non-SYNC byte in IDLE is ignored
        send(8'h3C);
        check("idle_ignore_busy", {31'd0, busy}, 32'd0);

        // Table of complete frames
        for (int v = 0; v < 5; v++) begin
            wr_q.delete();
            send_hdr(vec[v].addr, vec[v].n);
            if (vec[v].resp == 8'h5A) begin
                for (int w = 0; w < vec[v].n; w++) begin
                    wd = (w == 0) ? vec[v].w0 : vec[v].w1;
                    for (int b = 0; b < 4; b++) send(wd[8*b +: 8]);
                end
            end
            wait_tx(cyc);
            check($sformatf("v%0d_tx_valid", v), {31'd0, tx_valid}, 32'd1);
            check($sformatf("v%0d_tx_data", v), {24'd0, tx_data}, {24'd0, vec[v].resp});
            tick();
            check($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vec[v].exp_err});
            check($sformatf("v%0d_cpu", v), {31'd0, cpu_n_reset}, {31'd0, vec[v].exp_cpu});
            tick();
            check($sformatf("v%0d_nwr", v), wr_q.size(), vec[v].nwr);
            if (wr_q.size() >= 1 && vec[v].nwr >= 1) begin
                check($sformatf("v%0d_a0", v), wr_q[0].adr, vec[v].a0);
                check($sformatf("v%0d_d0", v), wr_q[0].dat, vec[v].d0);
            end
            if (wr_q.size() >= 2 && vec[v].nwr >= 2) begin
                check($sformatf("v%0d_a1", v), wr_q[1].adr, vec[v].a1);
                check($sformatf("v%0d_d1", v), wr_q[1].dat, vec[v].d1);
            end
        end

        // Timeout: N=1 with only three data bytes, then silence
        wr_q.delete();
        send_hdr(32'h00000400, 16'd1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        wait_tx(cyc);
        check("tmo_cycles", cyc, 32'd100);
        check("tmo_tx_data", {24'd0, tx_data}, 32'h000000EE);
        tick();
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_cpu", {31'd0, cpu_n_reset}, 32'd0);
        check("tmo_nwr", wr_q.size(), 32'd0);

        // ACK held off by tx_ready; a byte arriving during ACK is dropped
        tx_ready = 1'b0;
        send_hdr(32'h00000100, 16'd0);
        hold_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!tx_valid || tx_data != 8'h5A || cpu_n_reset != 1'b0 || busy != 1'b1)
                hold_bad = 1'b1;
            if (i == 10) begin
                rx_data  = 8'hA5;
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
        end
        check("ack_hold_stable", {31'd0, hold_bad}, 32'd0);
        tx_ready = 1'b1;
        tick();
        check("ack_release_cpu", {31'd0, cpu_n_reset}, 32'd1);
        check("ack_release_err", {31'd0, err}, 32'd0);
        tick();
        check("ack_drop_busy", {31'd0, busy}, 32'd0);

        // Strobe timing, byte during strobe, then reset mid-DATA
        wr_q.delete();
        send_hdr(32'h00000300, 16'd2);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("k1_mem_op", {31'd0, dbg_mem_op}, 32'd1);
        check("k1_wren", {28'd0, dbg_wren}, 32'hF);
        check("k1_adr", dbg_adr, 32'h00000300);
        check("k1_do", dbg_do, 32'h44332211);
        send(8'h55);
        check("k2_mem_op", {31'd0, dbg_mem_op}, 32'd0);
        check("k2_adr_hold", dbg_adr, 32'h00000300);
        check("k2_do_hold", dbg_do, 32'h44332211);
        send(8'h66);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_adr", dbg_adr, 32'd0);
        check("mid_rst_do", dbg_do, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cpu", {31'd0, cpu_n_reset}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        send(8'h77);
        send(8'h88);
        repeat (5) tick();
        check("mid_rst_nwr", wr_q.size(), 32'd1);
        check("mid_rst_busy_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the UART receiver's byte stream and the SoC debug memory port (dbg_mem_op/dbg_wren/dbg_adr/dbg_do, cpu_n_reset).
- Receives framed program images over UART and writes them word-by-word into memory while holding the CPU in reset.
- Acknowledges each frame through the UART transmitter, then releases the CPU.
- Replaces forcing the debug port from a bench with a real in-system loader.

Parameters:
- F_CLK, 12000000, system clock frequency in Hz (informational; used to derive TIMEOUT default).
- TIMEOUT, 120000, inter-byte idle limit in clk cycles while inside a frame.
- BOOT_HOLD, 1, 1 = CPU held in reset after reset until the first good frame; 0 = CPU released out of reset.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  response byte to the UART transmitter.
- tx_valid  out  1  response request; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- dbg_mem_op  out  1  memory write strobe, one cycle per word.
- dbg_wren  out  4  byte enables; 4'hF during a write, 4'h0 otherwise.
- dbg_adr  out  32  word write address.
- dbg_do  out  32  write data.
- cpu_n_reset  out  1  CPU reset, active low.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set on NAK, cleared by the next good ACK or by reset.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0.
  - dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0.
  - busy=0, err=0.
  - cpu_n_reset = ~BOOT_HOLD.
  - state=IDLE; all counters 0.
- Frame format:
  - SYNC byte.
  - Address: 4 bytes, little-endian.
  - Word count N: 2 bytes, little-endian.
  - Data: N×4 bytes, each word little-endian.
- States: IDLE, ADDR, CNT, DATA, ACK, NAK.
- IDLE:
  - rx_valid with rx_data==SYNC → ADDR; cpu_n_reset=0 from the next cycle.
  - Any other byte is ignored.
- ADDR: collects 4 bytes → CNT.
- CNT: collects 2 bytes.
  - If address[1:0]!=0 → NAK.
  - Else if N==0 → ACK.
  - Else → DATA.
- DATA:
  - Shifts bytes into a 32-bit assembly register, LSB first.
  - On the 4th byte accepted in cycle k, cycle k+1 has dbg_mem_op=1, dbg_wren=4'hF, dbg_adr=current address, dbg_do=assembled word.
  - In cycle k+2 dbg_mem_op and dbg_wren return to 0; dbg_adr and dbg_do hold their values.
  - Address increments by 4 after each write, wrapping modulo 2^32. The word counter decrements.
  - When the last word's write strobe is issued → ACK.
  - A byte arriving during the strobe cycle is accepted normally.
- ACK:
  - tx_data=8'h5A, tx_valid=1 until tx_ready.
  - After the handshake cycle: cpu_n_reset=1 on the next cycle, err=0, → IDLE.
- NAK:
  - tx_data=8'hEE, tx_valid=1 until tx_ready.
  - err=1; cpu_n_reset stays 0; → IDLE.
- Timeout:
  - In ADDR, CNT and DATA a counter clears on every rx_valid and increments otherwise.
  - Reaching TIMEOUT-1 → NAK. Partial words are discarded, never written.
- rx_valid in ACK or NAK: byte is dropped.
- A SYNC value inside ADDR, CNT or DATA is treated as data, not a restart.
- Reset mid-frame or mid-handshake:
  - Returns to IDLE next cycle with all outputs at their reset values.
  - No further writes are issued.
- dbg_mem_op is never high for more than one consecutive cycle.
- tx_data is stable while tx_valid is high.

Test Plan:
1. Reset with BOOT_HOLD=1, no input → cpu_n_reset=0, busy=0, dbg_mem_op=0, tx_valid=0.
2. Frame A5, 00 00 02 00, 02 00, then bytes b7 07 01 00 13 05 10 06 with tx_ready=1:
   - Write at 0x20000 of 0x000107B7, then write at 0x20004 of 0x06100513, each a single-cycle strobe with wren=F.
   - Then tx_data=0x5A, then cpu_n_reset=1, err=0.
3. Frame A5, 02 00 02 00, 01 00 → NAK 0xEE, err=1, no dbg_mem_op pulse, cpu_n_reset=0.
4. Frame with N=0 (A5, 00 00 02 00, 00 00) → immediate ACK 0x5A, no writes, cpu_n_reset=1.
5. Frame with N=1 and only 3 data bytes, then silence (TIMEOUT=100) → NAK after 100 idle cycles, no write issued.
6. tx_ready held low 50 cycles during ACK → tx_valid and tx_data=0x5A stable, cpu_n_reset rises only after the handshake. Repeat with reset asserted mid-DATA → all outputs return to reset values.
